// File: rtl/fifo_sync_thresh.sv
// Single-clock synchronous FIFO with programmable almost-full/almost-empty levels,
// occupancy count, write acknowledge, overflow/underflow pulses and optional FWFT read.
module fifo_sync_thresh #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 512,
    parameter int AF_LEVEL   = FIFO_DEPTH - 4,
    parameter int AE_LEVEL   = 4,
    parameter bit FWFT       = 1'b0,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int            PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_ack_q, overflow_q, underflow_q;
    logic                  wr_acc, rd_acc;

    // Flags decode the registered count only, so a same-cycle read never frees space for a write.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PW'(1);
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_acc;
            overflow_q  <= wr_en && full;
            underflow_q <= rd_en && empty;
        end
    end

    // NOTE: storage has no reset; stale words are unreachable once the pointers and count clear.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    if (FWFT) begin : g_fwft
        // Head word is visible as soon as it is stored; rd_en only acknowledges it.
        assign dout = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
        logic [FIFO_WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (rd_acc) begin
                dout_d = mem_q[rd_ptr_q];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign dout = dout_q;
    end

endmodule

// File: doc/fifo_sync_thresh.md
# fifo_sync_thresh

Single-clock, fully parametrised synchronous FIFO. It is the next generation of the team's FIFO buffer, for blocks that share one clock domain. Beyond full/empty it adds programmable almost-full/almost-empty thresholds, an occupancy count, write acknowledge, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain and replaces ad-hoc buffering in datapath blocks.

## Interface
- FIFO_WIDTH, 16: data word width in bits (≥1).
- FIFO_DEPTH, 512: number of storage words (≥2; need not be a power of two).
- AF_LEVEL, FIFO_DEPTH-4: almost_full asserts when count ≥ AF_LEVEL (1..FIFO_DEPTH).
- AE_LEVEL, 4: almost_empty asserts when count ≤ AE_LEVEL (0..FIFO_DEPTH-1).
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- CW (local), $clog2(FIFO_DEPTH+1): count width.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  FIFO_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- dout  out  FIFO_WIDTH  read data.
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  CW  current occupancy.
- wr_ack  out  1  one-cycle pulse confirming an accepted write.
- overflow  out  1  one-cycle pulse when a write was rejected.
- underflow  out  1  one-cycle pulse when a read was rejected.

## Operation
- Storage: FIFO_DEPTH × FIFO_WIDTH array. wr_ptr and rd_ptr each range 0..FIFO_DEPTH-1 and wrap to 0 explicitly after FIFO_DEPTH-1, with no reliance on binary rollover. The count register is the single source of truth for all flags.
- Write accepted (wr_acc) = wr_en && !full. When accepted: mem[wr_ptr] <= din and wr_ptr advances.
- Read accepted (rd_acc) = rd_en && !empty. When accepted: rd_ptr advances.
- The flags are evaluated on the pre-edge state, so a simultaneous read does not free space for a same-cycle write:
  - Full with wr_en && rd_en: the read is accepted, the write is rejected and overflow pulses.
  - Empty with wr_en && rd_en: the write is accepted, the read is rejected and underflow pulses.
- count next value: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither.
- full, empty, almost_full and almost_empty are combinational decodes of the registered count. They have no extra pipeline delay.
- wr_ack <= wr_acc. overflow <= wr_en && full. underflow <= rd_en && empty. All three are registered and high for exactly one cycle per event.
- FWFT=0: dout is a register, loaded with mem[rd_ptr] on rd_acc and holding its value otherwise.
- FWFT=1: dout = mem[rd_ptr] when !empty and 0 when empty. rd_en acts as an acknowledge that pops the head word.
- Reset (asynchronous assert, synchronous-safe release): wr_ptr=0, rd_ptr=0, count=0, dout=0, wr_ack=0, overflow=0, underflow=0. The resulting flag values are empty=1, almost_empty=1, full=0 and almost_full=0 (AF_LEVEL ≥ 1). Memory contents are not reset.
- Asserting reset mid-operation discards all stored words immediately. The first post-reset write lands at address 0.

## Timing
- Write-to-flag latency: count and the flags reflect a write on the edge that accepts it.
- Empty-to-readable: one cycle after the accepting edge.
  - FWFT=1: the data appears on dout in that same cycle.
  - FWFT=0: rd_en must be asserted that cycle, and dout is valid one cycle later.
- Standard read latency (FWFT=0): 1 cycle from the rd_acc edge to dout.
- Throughput: one write and one read per cycle sustained when 0 < count < FIFO_DEPTH.
- Pointer wrap: an access at index FIFO_DEPTH-1 moves the pointer to 0 on the same edge, for any FIFO_DEPTH, including non-powers of two.

## Test plan
- Reset, then write 0x0001..0x0200 (512 writes, default params): full=1 after the 512th edge and almost_full=1 from count=508. wr_ack pulses 512 times. A 513th write → overflow=1 for one cycle, count stays 512.
- From full, read 512 words with FWFT=0: dout sequence is 0x0001..0x0200, each one cycle after its rd_en edge. empty=1 after the last read, almost_empty=1 from count=4. An extra read → underflow=1, dout holds 0x0200.
- FIFO_DEPTH=5 (non-power-of-two): run 23 mixed writes and reads crossing the wrap several times → data order preserved and count matches the reference model at every edge.
- Simultaneous wr_en/rd_en at count=0, count=3 and count=FIFO_DEPTH:
  - count=0: write only, underflow pulses.
  - count=3: count unchanged and data streams through.
  - count=FIFO_DEPTH: read only, overflow pulses.
- FWFT=1: write 0xABCD into an empty FIFO → dout=0xABCD one cycle later with no rd_en. rd_en pops it and dout=0 with empty=1.
- Assert rst_n=0 asynchronously mid-burst at count=7 → all outputs reach their reset values before the next clock edge. After release, the first written word is read back first.
